seq_addsub: RTL and testbench

- Multi-cycle, parametrised add/subtract unit; successor to the fixed 4-bit combinational subtractor.
- Processes operands LSB-first, DIGIT bits per clock, under a start/done handshake.
- Supports add and subtract modes, carry/borrow in and carry/borrow out.
- Sits in the arithmetic datapath where area matters more than latency.

---
 rtl/seq_addsub.sv | 102 ++++++++++
 tb/tb_seq_addsub.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// Sequential digit-serial add/subtract unit: DIGIT bits per clock, LSB first, start/done handshake.
// Optional macro SEQ_ADDSUB_SAT_EN enables unsigned saturation of the result on completion.
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             sub;

  logic [DIGIT:0]   chunk;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] result;
  logic             raw_c;

  // Subtraction runs as a + ~b + ~c_in, so b and c_in are inverted once at load time.
  always_comb begin
    chunk    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    acc_next = (acc >> DIGIT) | (WIDTH'(chunk[DIGIT-1:0]) << (WIDTH - DIGIT));
    raw_c    = sub ? ~chunk[DIGIT] : chunk[DIGIT];
    result   = acc_next;
`ifdef SEQ_ADDSUB_SAT_EN
    if (raw_c) begin
      result = sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      sub   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= mode ? ~b : b;
            carry <= c_in ^ mode;
            sub   <= mode;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          acc   <= acc_next;
          carry <= chunk[DIGIT];
          // Result registers are touched only on the final chunk so partial sums never leak out.
          if (cnt == LAST) begin
            s     <= result;
            c_out <= raw_c;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: 8-bit/1-bit, 16-bit/4-bit and 8-bit/8-bit (single chunk) builds.
// Expected results come from plain integer arithmetic on the operands.
module tb_seq_addsub;

  logic        clk;
  logic        rst_n;

  logic        start8, mode8, c_in8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, c8;
  logic [7:0]  s8;

  logic        busy1, done1, c1;
  logic [7:0]  s1;

  logic        start16, mode16, c_in16;
  logic [15:0] a16, b16;
  logic        busy16, done16, c16;
  logic [15:0] s16;

  int n_checks = 0;
  int n_errors = 0;

  seq_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8), .c_in(c_in8),
    .busy(busy8), .done(done8), .s(s8), .c_out(c8)
  );

  seq_addsub #(.WIDTH(8), .DIGIT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8), .c_in(c_in8),
    .busy(busy1), .done(done1), .s(s1), .c_out(c1)
  );

  seq_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .a(a16), .b(b16), .c_in(c_in16),
    .busy(busy16), .done(done16), .s(s16), .c_out(c16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          which;
    bit          m;
    int unsigned av;
    int unsigned bv;
    bit          ci;
    int unsigned es;
    bit          ec;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference: unsigned integer arithmetic straight from the add/subtract definitions.
  function automatic void model(input int w, input bit m, input longint av, input longint bv,
                                input bit ci, output longint es, output bit ec);
    longint lim;
    lim = longint'(1) << w;
    if (!m) begin
      es = av + bv + ci;
      ec = (es >= lim);
      es = es % lim;
`ifdef SEQ_ADDSUB_SAT_EN
      if (ec) es = lim - 1;
`endif
    end else begin
      ec = (av < bv + ci);
      es = (av + lim - bv - ci) % lim;
`ifdef SEQ_ADDSUB_SAT_EN
      if (ec) es = 0;
`endif
    end
  endfunction

  function automatic logic sel_done(input int which);
    return (which == 0) ? done8 : done16;
  endfunction

  function automatic logic sel_busy(input int which);
    return (which == 0) ? busy8 : busy16;
  endfunction

  // Launch one operation, then follow it to its done pulse and one cycle beyond.
  task automatic apply_stimulus(input int which, input bit m, input int unsigned av,
                                input int unsigned bv, input bit ci,
                                output logic [15:0] s_got, output bit c_got, output int lat,
                                output bit busy_ok, output bit pulse_ok);
    @(negedge clk);
    if (which == 0) begin
      mode8 = m; a8 = av[7:0]; b8 = bv[7:0]; c_in8 = ci; start8 = 1'b1;
    end else begin
      mode16 = m; a16 = av[15:0]; b16 = bv[15:0]; c_in16 = ci; start16 = 1'b1;
    end
    @(posedge clk); #1;
    start8  = 1'b0;
    start16 = 1'b0;
    busy_ok = (sel_busy(which) === 1'b1) && (sel_done(which) === 1'b0);
    lat = 0;
    while (sel_done(which) !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (sel_done(which) !== 1'b1 && sel_busy(which) !== 1'b1) busy_ok = 1'b0;
    end
    if (sel_busy(which) !== 1'b0) busy_ok = 1'b0;
    s_got = (which == 0) ? {8'h00, s8} : s16;
    c_got = (which == 0) ? c8 : c16;
    @(posedge clk); #1;
    pulse_ok = (sel_done(which) === 1'b0);
  endtask

  task automatic check_output(input string name, input int which, input bit m,
                              input int unsigned av, input int unsigned bv, input bit ci,
                              input int unsigned es, input bit ec);
    logic [15:0] s_got;
    bit c_got, busy_ok, pulse_ok;
    int lat;
    apply_stimulus(which, m, av, bv, ci, s_got, c_got, lat, busy_ok, pulse_ok);
    check({name, "_s"}, {16'h0, s_got}, es);
    check({name, "_c"}, {31'h0, c_got}, {31'h0, ec});
    check({name, "_lat"}, lat, (which == 0) ? 8 : 4);
    check({name, "_busy"}, {31'h0, busy_ok}, 32'd1);
    check({name, "_pulse"}, {31'h0, pulse_ok}, 32'd1);
  endtask

  initial begin
    vec_t vecs[9];
    longint es;
    bit ec;
    int lat;
    bit saw_done;

    vecs[0] = '{0, 1'b1, 32'h96, 32'h36, 1'b0, 32'h60, 1'b0};
    vecs[1] = '{0, 1'b1, 32'h07, 32'h03, 1'b1, 32'h03, 1'b0};
`ifdef SEQ_ADDSUB_SAT_EN
    vecs[2] = '{0, 1'b1, 32'h02, 32'h05, 1'b1, 32'h00, 1'b1};
    vecs[3] = '{0, 1'b0, 32'hF0, 32'h20, 1'b0, 32'hFF, 1'b1};
    vecs[6] = '{0, 1'b1, 32'h00, 32'hFF, 1'b1, 32'h00, 1'b1};
    vecs[8] = '{1, 1'b0, 32'hFFFF, 32'h0001, 1'b0, 32'hFFFF, 1'b1};
`else
    vecs[2] = '{0, 1'b1, 32'h02, 32'h05, 1'b1, 32'hFC, 1'b1};
    vecs[3] = '{0, 1'b0, 32'hF0, 32'h20, 1'b0, 32'h10, 1'b1};
    vecs[6] = '{0, 1'b1, 32'h00, 32'hFF, 1'b1, 32'h00, 1'b1};
    vecs[8] = '{1, 1'b0, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1};
`endif
    vecs[4] = '{0, 1'b0, 32'h7F, 32'h00, 1'b1, 32'h80, 1'b0};
    vecs[5] = '{0, 1'b0, 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1};
    vecs[7] = '{1, 1'b1, 32'h1234, 32'h0235, 1'b0, 32'h0FFF, 1'b0};

    rst_n = 1'b0;
    start8 = 0; mode8 = 0; a8 = 0; b8 = 0; c_in8 = 0;
    start16 = 0; mode16 = 0; a16 = 0; b16 = 0; c_in16 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", {31'h0, busy8}, 0);
    check("rst_done8", {31'h0, done8}, 0);
    check("rst_s8", {24'h0, s8}, 0);
    check("rst_c8", {31'h0, c8}, 0);
    check("rst_busy16", {31'h0, busy16}, 0);
    check("rst_s16", {16'h0, s16}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      check_output($sformatf("vec%0d", i), vecs[i].which, vecs[i].m, vecs[i].av, vecs[i].bv,
                   vecs[i].ci, vecs[i].es, vecs[i].ec);
    end

    for (int i = 0; i < 30; i++) begin
      bit m, ci;
      int unsigned av, bv;
      m  = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      av = $urandom_range(0, 255);
      bv = $urandom_range(0, 255);
      model(8, m, av, bv, ci, es, ec);
      check_output($sformatf("rand8_%0d", i), 0, m, av, bv, ci, 32'(es), ec);
    end

    for (int i = 0; i < 15; i++) begin
      bit m, ci;
      int unsigned av, bv;
      m  = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      av = $urandom_range(0, 65535);
      bv = $urandom_range(0, 65535);
      model(16, m, av, bv, ci, es, ec);
      check_output($sformatf("rand16_%0d", i), 1, m, av, bv, ci, 32'(es), ec);
    end

    // Single-chunk build: done one cycle after start.
    @(negedge clk);
    mode8 = 1; a8 = 8'h96; b8 = 8'h36; c_in8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    check("n1_busy", {31'h0, busy1}, 1);
    check("n1_done_early", {31'h0, done1}, 0);
    @(posedge clk); #1;
    check("n1_done", {31'h0, done1}, 1);
    check("n1_s", {24'h0, s1}, 32'h60);
    check("n1_c", {31'h0, c1}, 0);
    @(posedge clk); #1;
    check("n1_pulse", {31'h0, done1}, 0);
    lat = 0;
    while (done8 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    @(posedge clk); #1;

    // A start during RUN must not disturb the operation in flight.
    @(negedge clk);
    mode8 = 1; a8 = 8'h96; b8 = 8'h36; c_in8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    mode8 = 0; a8 = 8'h11; b8 = 8'h22; c_in8 = 1; start8 = 1;
    @(posedge clk); #1;
    lat++;
    start8 = 0;
    while (done8 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("ign_lat", lat, 8);
    check("ign_s", {24'h0, s8}, 32'h60);
    check("ign_c", {31'h0, c8}, 0);
    @(posedge clk); #1;
    check("ign_pulse", {31'h0, done8}, 0);

    // Start held high through done: back-to-back operations.
    @(negedge clk);
    mode8 = 0; a8 = 8'hF0; b8 = 8'h20; c_in8 = 0; start8 = 1;
    @(posedge clk); #1;
    lat = 0;
    while (done8 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    model(8, 0, 64'hF0, 64'h20, 0, es, ec);
    check("b2b_a_lat", lat, 8);
    check("b2b_a_s", {24'h0, s8}, 32'(es));
    check("b2b_a_c", {31'h0, c8}, {31'h0, ec});
    @(negedge clk);
    mode8 = 1; a8 = 8'h02; b8 = 8'h05; c_in8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    check("b2b_done_drop", {31'h0, done8}, 0);
    check("b2b_busy", {31'h0, busy8}, 1);
    lat = 0;
    while (done8 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    model(8, 1, 64'h02, 64'h05, 1, es, ec);
    check("b2b_b_lat", lat, 8);
    check("b2b_b_s", {24'h0, s8}, 32'(es));
    check("b2b_b_c", {31'h0, c8}, {31'h0, ec});
    @(posedge clk); #1;
    check("b2b_pulse", {31'h0, done8}, 0);

    // Leave a nonzero result, then reset in the middle of a new operation.
    check_output("pre_rst", 0, 1, 32'h96, 32'h36, 0, 32'h60, 0);
    @(negedge clk);
    mode8 = 0; a8 = 8'h7F; b8 = 8'h00; c_in8 = 1; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'h0, busy8}, 0);
    check("mid_rst_done", {31'h0, done8}, 0);
    check("mid_rst_s", {24'h0, s8}, 0);
    check("mid_rst_c", {31'h0, c8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
    end
    check("mid_rst_quiet", {31'h0, saw_done}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
